bsg_manycore_rocc_dma_sched: RTL and testbench

Multi-requester descriptor scheduler in front of the manycore RoCC DMA engine.
- Accepts complete DMA descriptors from `num_req_p` requesters and arbitrates round-robin.
- Queues accepted descriptors in a small FIFO.
- For each descriptor, replays the addr → skip → xfer command sequence on the DMA command port, waits for the transfer to finish, and reports completion with the requester id.
- Sits between on-chip DMA clients and the DMA engine's core command interface.

---
 rtl/bsg_manycore_rocc_dma_sched.sv | 204 ++++++++++++++++++++
 tb/tb_bsg_manycore_rocc_dma_sched.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_manycore_rocc_dma_sched.sv
// Descriptor scheduler in front of the manycore RoCC DMA engine.
// Requesters hand over complete descriptors through a round-robin arbiter.
// Accepted descriptors wait in a small FIFO. The sequencer replays each
// descriptor as addr -> skip -> xfer commands, waits for the engine to go
// busy and then idle again, and reports completion with the requester id.
module bsg_manycore_rocc_dma_sched #(
    parameter int          num_req_p    = 2,
    parameter int          addr_width_p = 64,
    parameter int          cfg_width_p  = 16,
    parameter int          fifo_els_p   = 4,
    // Defaults follow the eRoCC_core_dma_{addr,skip,xfer} funct7 encodings.
    parameter logic [6:0]  funct_addr_p = 7'd1,
    parameter logic [6:0]  funct_skip_p = 7'd2,
    parameter logic [6:0]  funct_xfer_p = 7'd3,
    localparam int         lg_req_lp    = (num_req_p > 1) ? $clog2(num_req_p) : 1
) (
    input  logic                              clk_i,
    input  logic                              reset_n_i,
    input  logic [num_req_p-1:0]              req_v_i,
    output logic [num_req_p-1:0]              req_ready_o,
    input  logic [num_req_p*addr_width_p-1:0] req_mc_addr_i,
    input  logic [num_req_p*addr_width_p-1:0] req_rkt_addr_i,
    input  logic [num_req_p*addr_width_p-1:0] req_mc_skip_i,
    input  logic [num_req_p*addr_width_p-1:0] req_rkt_skip_i,
    input  logic [num_req_p*cfg_width_p-1:0]  req_run_bytes_i,
    input  logic [num_req_p*cfg_width_p-1:0]  req_repeats_i,
    output logic                              dma_cmd_v_o,
    output logic [6:0]                        dma_cmd_funct_o,
    output logic [63:0]                       dma_cmd_rs1_o,
    output logic [63:0]                       dma_cmd_rs2_o,
    input  logic                              dma_cmd_ready_i,
    output logic                              done_v_o,
    output logic [lg_req_lp-1:0]              done_id_o,
    output logic                              busy_o
);

    localparam int lg_els_lp     = $clog2(fifo_els_p);
    localparam int aw_lp         = addr_width_p;
    localparam int cw_lp         = cfg_width_p;
    localparam int desc_width_lp = 4*aw_lp + 2*cw_lp + lg_req_lp;
    localparam logic [lg_els_lp:0] full_count_lp = (lg_els_lp+1)'(fifo_els_p);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ADDR      = 3'd1,
        SKIP      = 3'd2,
        XFER      = 3'd3,
        WAIT_BUSY = 3'd4,
        WAIT_IDLE = 3'd5
    } state_e;

    state_e                   state_r, state_n;
    logic [lg_els_lp:0]       count_r;
    logic [lg_els_lp-1:0]     rd_ptr_r, wr_ptr_r;
    logic [lg_req_lp-1:0]     rr_ptr_r, rr_next_s;
    logic [desc_width_lp-1:0] mem_r [fifo_els_p];
    logic [desc_width_lp-1:0] wr_desc_s, head_s;

    logic                 fifo_full_s;
    logic                 grant_v_s;
    logic [lg_req_lp-1:0] grant_id_s;
    logic                 enq_s, deq_s;
    logic                 cmd_v_s, done_v_s;
    logic [6:0]           funct_s;
    logic [63:0]          rs1_s, rs2_s;
    logic [lg_req_lp-1:0] done_id_s;

    assign fifo_full_s = (count_r == full_count_lp);
    assign enq_s       = grant_v_s;

    // Descriptor layout in the queue: id in the MSBs, mc_addr in the LSBs.
    assign wr_desc_s = {grant_id_s,
                        req_repeats_i  [grant_id_s*cw_lp +: cw_lp],
                        req_run_bytes_i[grant_id_s*cw_lp +: cw_lp],
                        req_rkt_skip_i [grant_id_s*aw_lp +: aw_lp],
                        req_mc_skip_i  [grant_id_s*aw_lp +: aw_lp],
                        req_rkt_addr_i [grant_id_s*aw_lp +: aw_lp],
                        req_mc_addr_i  [grant_id_s*aw_lp +: aw_lp]};
    assign head_s = mem_r[rd_ptr_r];

    // Round-robin arbiter: first valid requester at or after the pointer, only when the queue has room.
    always_comb begin
        grant_v_s  = 1'b0;
        grant_id_s = '0;
        for (int i = 0; i < num_req_p; i++) begin
            if (!grant_v_s && !fifo_full_s && req_v_i[(int'(rr_ptr_r) + i) % num_req_p]) begin
                grant_v_s  = 1'b1;
                grant_id_s = lg_req_lp'((int'(rr_ptr_r) + i) % num_req_p);
            end else begin
                grant_v_s  = grant_v_s;
            end
        end
    end

    // One-hot accept and the pointer value that follows a grant.
    always_comb begin
        req_ready_o = '0;
        rr_next_s   = '0;
        if (grant_v_s) begin
            req_ready_o[grant_id_s] = 1'b1;
        end else begin
            req_ready_o = '0;
        end
        if (grant_id_s == lg_req_lp'(num_req_p - 1)) begin
            rr_next_s = '0;
        end else begin
            rr_next_s = grant_id_s + lg_req_lp'(1);
        end
    end

    // Sequencer next state and command/completion outputs taken from the queue head.
    always_comb begin
        state_n   = state_r;
        cmd_v_s   = 1'b0;
        funct_s   = 7'd0;
        rs1_s     = 64'd0;
        rs2_s     = 64'd0;
        deq_s     = 1'b0;
        done_v_s  = 1'b0;
        done_id_s = '0;
        case (state_r)
            IDLE: begin
                if (count_r != '0) state_n = ADDR;
                else               state_n = IDLE;
            end
            ADDR: begin
                cmd_v_s = 1'b1;
                funct_s = funct_addr_p;
                rs1_s   = 64'(head_s[0*aw_lp +: aw_lp]);
                rs2_s   = 64'(head_s[1*aw_lp +: aw_lp]);
                if (dma_cmd_ready_i) state_n = SKIP;
                else                 state_n = ADDR;
            end
            SKIP: begin
                cmd_v_s = 1'b1;
                funct_s = funct_skip_p;
                rs1_s   = 64'(head_s[2*aw_lp +: aw_lp]);
                rs2_s   = 64'(head_s[3*aw_lp +: aw_lp]);
                if (dma_cmd_ready_i) state_n = XFER;
                else                 state_n = SKIP;
            end
            XFER: begin
                cmd_v_s = 1'b1;
                funct_s = funct_xfer_p;
                rs1_s   = 64'(head_s[4*aw_lp +: cw_lp]);
                rs2_s   = 64'(head_s[4*aw_lp + cw_lp +: cw_lp]);
                if (dma_cmd_ready_i) state_n = WAIT_BUSY;
                else                 state_n = XFER;
            end
            WAIT_BUSY: begin
                if (!dma_cmd_ready_i) state_n = WAIT_IDLE;
                else                  state_n = WAIT_BUSY;
            end
            WAIT_IDLE: begin
                if (dma_cmd_ready_i) begin
                    deq_s     = 1'b1;
                    done_v_s  = 1'b1;
                    done_id_s = head_s[desc_width_lp-1 -: lg_req_lp];
                    state_n   = IDLE;
                end else begin
                    state_n   = WAIT_IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign dma_cmd_v_o     = cmd_v_s;
    assign dma_cmd_funct_o = funct_s;
    assign dma_cmd_rs1_o   = rs1_s;
    assign dma_cmd_rs2_o   = rs2_s;
    assign done_v_o        = done_v_s;
    assign done_id_o       = done_id_s;
    assign busy_o          = (state_r != IDLE) | (count_r != '0);

    // Descriptor storage; contents are don't-care until counted as valid.
    always_ff @(posedge clk_i) begin
        if (enq_s) mem_r[wr_ptr_r] <= wr_desc_s;
    end

    // Control state: sequencer, queue pointers/count, arbiter pointer.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_r  <= IDLE;
            count_r  <= '0;
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            rr_ptr_r <= '0;
        end else begin
            state_r <= state_n;
            if (enq_s) begin
                wr_ptr_r <= wr_ptr_r + lg_els_lp'(1);
                rr_ptr_r <= rr_next_s;
            end
            if (deq_s) rd_ptr_r <= rd_ptr_r + lg_els_lp'(1);
            case ({enq_s, deq_s})
                2'b10:   count_r <= count_r + (lg_els_lp+1)'(1);
                2'b01:   count_r <= count_r - (lg_els_lp+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: tb/tb_bsg_manycore_rocc_dma_sched.sv
// Directed bench for the DMA descriptor scheduler: a cycle table for
// single-descriptor command replay and backpressure, plus hand sequences
// for arbitration, queue fill, mid-transfer reset and simultaneous push/pop.
module tb_bsg_manycore_rocc_dma_sched;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [1:0]   req_v;
    logic [1:0]   req_ready;
    logic [127:0] mc_addr, rkt_addr, mc_skip, rkt_skip;
    logic [31:0]  run_bytes, repeats;
    logic         cmd_v;
    logic [6:0]   funct;
    logic [63:0]  rs1, rs2;
    logic         dma_ready;
    logic         done_v;
    logic [0:0]   done_id;
    logic         busy;

    always #5 clk = ~clk;

    bsg_manycore_rocc_dma_sched #(
        .num_req_p(2), .addr_width_p(64), .cfg_width_p(16), .fifo_els_p(4),
        .funct_addr_p(7'd1), .funct_skip_p(7'd2), .funct_xfer_p(7'd3)
    ) dut (
        .clk_i(clk), .reset_n_i(reset_n),
        .req_v_i(req_v), .req_ready_o(req_ready),
        .req_mc_addr_i(mc_addr), .req_rkt_addr_i(rkt_addr),
        .req_mc_skip_i(mc_skip), .req_rkt_skip_i(rkt_skip),
        .req_run_bytes_i(run_bytes), .req_repeats_i(repeats),
        .dma_cmd_v_o(cmd_v), .dma_cmd_funct_o(funct),
        .dma_cmd_rs1_o(rs1), .dma_cmd_rs2_o(rs2),
        .dma_cmd_ready_i(dma_ready),
        .done_v_o(done_v), .done_id_o(done_id), .busy_o(busy)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic check_seq(input string name, input longint got[$], input longint exp[$]);
        check({name, "_len"}, 64'(got.size()), 64'(exp.size()));
        for (int j = 0; j < exp.size(); j++) begin
            if (j < got.size()) begin
                check($sformatf("%s[%0d]", name, j), got[j], exp[j]);
            end else begin
                checks++;
                failures++;
                $display("FAIL %s[%0d] actual=missing expected=0x%0h", name, j, exp[j]);
            end
        end
    endtask

    typedef struct {
        logic [1:0]  req_v;
        logic        rdy;
        logic [1:0]  ready;
        logic        cmd_v;
        logic [6:0]  funct;
        logic [63:0] rs1;
        logic [63:0] rs2;
        logic        done_v;
        logic        done_id;
        logic        busy;
    } vec_t;
    vec_t vecs[$];

    function automatic void add(input logic [1:0] rv, input logic rd, input logic [1:0] ry,
                                input logic cv, input logic [6:0] fn, input logic [63:0] r1,
                                input logic [63:0] r2, input logic dv, input logic di, input logic bz);
        vec_t v;
        v.req_v = rv; v.rdy = rd; v.ready = ry; v.cmd_v = cv; v.funct = fn;
        v.rs1 = r1; v.rs2 = r2; v.done_v = dv; v.done_id = di; v.busy = bz;
        vecs.push_back(v);
    endfunction

    // Simple DMA model and observation records for the hand sequences.
    logic   model_en = 1'b0;
    int     busy_len = 0;
    int     busy_cnt = 0;
    int     cyc      = 0;
    logic   xfer_seen = 1'b0;
    longint grant_q[$], grant_cyc_q[$], done_q[$], done_cyc_q[$], addr_q[$];

    task automatic clear_obs();
        grant_q.delete(); grant_cyc_q.delete();
        done_q.delete();  done_cyc_q.delete();
        addr_q.delete();
        xfer_seen = 1'b0;
    endtask

    task automatic sample();
        check("ready_onehot0", 64'($onehot0(req_ready)), 64'd1);
        for (int g = 0; g < 2; g++) begin
            if (req_v[g] && req_ready[g]) begin
                grant_q.push_back(longint'(g));
                grant_cyc_q.push_back(longint'(cyc));
            end
        end
        if (done_v) begin
            done_q.push_back(longint'(done_id));
            done_cyc_q.push_back(longint'(cyc));
        end
        if (cmd_v && dma_ready) begin
            if (funct == 7'd1) addr_q.push_back(longint'(rs1));
            if (funct == 7'd3) begin
                busy_cnt  = busy_len;
                xfer_seen = 1'b1;
            end
        end
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        cyc++;
        if (model_en) begin
            if (busy_cnt > 0) begin
                dma_ready = 1'b0;
                busy_cnt--;
            end else begin
                dma_ready = 1'b1;
            end
        end
    endtask

    task automatic cycle();
        #4;
        sample();
        advance();
    endtask

    task automatic drain(input int n);
        for (int k = 0; k < 400 && done_q.size() < n; k++) cycle();
        check("drain_done_count", 64'(done_q.size()), 64'(n));
    endtask

    initial begin
        mc_addr   = {64'h2000, 64'h1000};
        rkt_addr  = {64'h9000, 64'h8000};
        mc_skip   = {64'h10,   64'h0};
        rkt_skip  = {64'h20,   64'h0};
        run_bytes = {16'd32,   16'd16};
        repeats   = {16'd2,    16'd1};
        reset_n   = 1'b0;
        req_v     = 2'b00;
        dma_ready = 1'b0;

        // Single descriptor from requester 0, DMA busy for 5 cycles.
        add(2'b01,1'b1,2'b01,1'b0,7'd0,64'h0,   64'h0,   1'b0,1'b0,1'b0);
        add(2'b00,1'b1,2'b00,1'b0,7'd0,64'h0,   64'h0,   1'b0,1'b0,1'b1);
        add(2'b00,1'b1,2'b00,1'b1,7'd1,64'h1000,64'h8000,1'b0,1'b0,1'b1);
        add(2'b00,1'b1,2'b00,1'b1,7'd2,64'h0,   64'h0,   1'b0,1'b0,1'b1);
        add(2'b00,1'b1,2'b00,1'b1,7'd3,64'd16,  64'd1,   1'b0,1'b0,1'b1);
        for (int k = 0; k < 5; k++)
            add(2'b00,1'b0,2'b00,1'b0,7'd0,64'h0,64'h0,1'b0,1'b0,1'b1);
        add(2'b00,1'b1,2'b00,1'b0,7'd0,64'h0,   64'h0,   1'b1,1'b0,1'b1);
        add(2'b00,1'b1,2'b00,1'b0,7'd0,64'h0,   64'h0,   1'b0,1'b0,1'b0);
        // Requester 1 with 3 cycles of backpressure during SKIP.
        add(2'b10,1'b1,2'b10,1'b0,7'd0,64'h0,   64'h0,   1'b0,1'b0,1'b0);
        add(2'b00,1'b1,2'b00,1'b0,7'd0,64'h0,   64'h0,   1'b0,1'b0,1'b1);
        add(2'b00,1'b1,2'b00,1'b1,7'd1,64'h2000,64'h9000,1'b0,1'b0,1'b1);
        for (int k = 0; k < 3; k++)
            add(2'b00,1'b0,2'b00,1'b1,7'd2,64'h10,64'h20,1'b0,1'b0,1'b1);
        add(2'b00,1'b1,2'b00,1'b1,7'd2,64'h10,  64'h20,  1'b0,1'b0,1'b1);
        add(2'b00,1'b1,2'b00,1'b1,7'd3,64'd32,  64'd2,   1'b0,1'b0,1'b1);
        add(2'b00,1'b0,2'b00,1'b0,7'd0,64'h0,   64'h0,   1'b0,1'b0,1'b1);
        add(2'b00,1'b1,2'b00,1'b0,7'd0,64'h0,   64'h0,   1'b1,1'b1,1'b1);
        add(2'b00,1'b1,2'b00,1'b0,7'd0,64'h0,   64'h0,   1'b0,1'b0,1'b0);

        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        #4;
        check("rst_cmd_v",   64'(cmd_v),     64'd0);
        check("rst_funct",   64'(funct),     64'd0);
        check("rst_rs1",     rs1,            64'd0);
        check("rst_rs2",     rs2,            64'd0);
        check("rst_done_v",  64'(done_v),    64'd0);
        check("rst_done_id", 64'(done_id),   64'd0);
        check("rst_busy",    64'(busy),      64'd0);
        check("rst_ready",   64'(req_ready), 64'd0);
        @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            req_v     = vecs[i].req_v;
            dma_ready = vecs[i].rdy;
            #4;
            check($sformatf("v%0d_ready", i), 64'(req_ready), 64'(vecs[i].ready));
            check($sformatf("v%0d_cmd_v", i), 64'(cmd_v),     64'(vecs[i].cmd_v));
            check($sformatf("v%0d_funct", i), 64'(funct),     64'(vecs[i].funct));
            check($sformatf("v%0d_rs1", i),   rs1,            vecs[i].rs1);
            check($sformatf("v%0d_rs2", i),   rs2,            vecs[i].rs2);
            check($sformatf("v%0d_done_v", i),64'(done_v),    64'(vecs[i].done_v));
            if (vecs[i].done_v)
                check($sformatf("v%0d_done_id", i), 64'(done_id), 64'(vecs[i].done_id));
            check($sformatf("v%0d_busy", i),  64'(busy),      64'(vecs[i].busy));
            @(posedge clk);
            #1;
        end

        // Both requesters valid: grants and completions alternate.
        clear_obs();
        model_en = 1'b1; busy_len = 5; busy_cnt = 0; dma_ready = 1'b1;
        req_v = 2'b11;
        for (int k = 0; k < 20 && grant_q.size() < 4; k++) cycle();
        req_v = 2'b00;
        drain(4);
        check_seq("rr_grants", grant_q, '{0, 1, 0, 1});
        check_seq("rr_done",   done_q,  '{0, 1, 0, 1});
        check_seq("rr_addr",   addr_q,  '{64'h1000, 64'h2000, 64'h1000, 64'h2000});

        // Queue fill: DMA stalled, 5th descriptor waits for the first pop.
        clear_obs();
        model_en = 1'b0; busy_cnt = 0; dma_ready = 1'b0;
        req_v = 2'b01;
        for (int k = 0; k < 8; k++) cycle();
        check("fill_accepted", 64'(grant_q.size()), 64'd4);
        #4;
        check("fill_ready_low", 64'(req_ready), 64'd0);
        sample();
        advance();
        model_en = 1'b1; busy_len = 3; busy_cnt = 0; dma_ready = 1'b1;
        for (int k = 0; k < 300 && grant_q.size() < 5; k++) cycle();
        req_v = 2'b00;
        if (grant_q.size() >= 5 && done_cyc_q.size() >= 1) begin
            check("fill_5th_after_pop", grant_cyc_q[4], done_cyc_q[0] + 64'd1);
        end else begin
            checks++;
            failures++;
            $display("FAIL fill_5th_after_pop actual=grants:%0d dones:%0d required=5 grants 1 done",
                     grant_q.size(), done_q.size());
        end
        drain(5);

        // Reset while waiting for the DMA with two descriptors queued behind it.
        clear_obs();
        model_en = 1'b1; busy_len = 10; busy_cnt = 0; dma_ready = 1'b1;
        req_v = 2'b01;
        for (int k = 0; k < 3; k++) cycle();
        req_v = 2'b00;
        for (int k = 0; k < 50 && !xfer_seen; k++) cycle();
        check("rst5_xfer_seen", 64'(xfer_seen), 64'd1);
        cycle();
        reset_n = 1'b0;
        cycle();
        reset_n = 1'b1;
        busy_cnt = 0;
        dma_ready = 1'b1;
        clear_obs();
        #4;
        check("rst5_cmd_v",   64'(cmd_v),     64'd0);
        check("rst5_funct",   64'(funct),     64'd0);
        check("rst5_rs1",     rs1,            64'd0);
        check("rst5_rs2",     rs2,            64'd0);
        check("rst5_done_v",  64'(done_v),    64'd0);
        check("rst5_done_id", 64'(done_id),   64'd0);
        check("rst5_busy",    64'(busy),      64'd0);
        sample();
        advance();
        for (int k = 0; k < 6; k++) cycle();
        #4;
        check("rst5_still_idle", 64'(busy),          64'd0);
        check("rst5_no_done",    64'(done_q.size()), 64'd0);
        check("rst5_no_cmds",    64'(addr_q.size()), 64'd0);
        sample();
        advance();
        req_v = 2'b11;
        cycle();
        req_v = 2'b00;
        drain(1);
        check_seq("rst5_grant", grant_q, '{0});
        check_seq("rst5_done",  done_q,  '{0});
        check_seq("rst5_addr",  addr_q,  '{64'h1000});

        // Push on the same cycle as a pop with three descriptors queued.
        clear_obs();
        model_en = 1'b1; busy_len = 6; busy_cnt = 0; dma_ready = 1'b1;
        req_v = 2'b01;
        for (int k = 0; k < 3; k++) cycle();
        req_v = 2'b00;
        begin
            logic sim;
            sim = 1'b0;
            for (int k = 0; k < 200; k++) begin
                #4;
                if (done_v) begin
                    sim = 1'b1;
                    req_v = 2'b10;
                    #1;
                end
                sample();
                advance();
                if (sim) break;
            end
            check("pp_pop_seen", 64'(sim), 64'd1);
        end
        if (grant_q.size() >= 4 && done_cyc_q.size() >= 1) begin
            check("pp_same_cycle", grant_cyc_q[3], done_cyc_q[0]);
        end else begin
            checks++;
            failures++;
            $display("FAIL pp_same_cycle actual=grants:%0d dones:%0d required=4 grants 1 done",
                     grant_q.size(), done_q.size());
        end
        req_v = 2'b01;
        #4;
        check("pp_count3_accept", 64'(req_ready), 64'd1);
        sample();
        advance();
        #4;
        check("pp_count4_full", 64'(req_ready), 64'd0);
        sample();
        advance();
        req_v = 2'b00;
        drain(5);
        check_seq("pp_done", done_q, '{0, 0, 0, 1, 0});
        check_seq("pp_addr", addr_q, '{64'h1000, 64'h1000, 64'h1000, 64'h2000, 64'h1000});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
